alu_arbiter: RTL and testbench

//  Shares one combinational alu (Operation[3:0] encoding: 0000 AND ... 1111 unsigned >=) between two requesters.

---
 rtl/alu_arbiter_if.sv | 43 ++++
 rtl/alu_arbiter.sv | 142 ++++++++++++++
 tb/tb_alu_arbiter.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/alu_arbiter_if.sv
// Bundle between the issue side, the shared alu and the response consumers.
// The master side is the requester/alu environment; the slave side is alu_arbiter.
interface alu_arbiter_if #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
);
    logic [1:0]               req_valid;
    logic [1:0]               req_ready;
    logic [DATA_WIDTH-1:0]    req_srca0;
    logic [DATA_WIDTH-1:0]    req_srca1;
    logic [DATA_WIDTH-1:0]    req_srcb0;
    logic [DATA_WIDTH-1:0]    req_srcb1;
    logic [OPCODE_LENGTH-1:0] req_op0;
    logic [OPCODE_LENGTH-1:0] req_op1;

    logic [DATA_WIDTH-1:0]    alu_srca;
    logic [DATA_WIDTH-1:0]    alu_srcb;
    logic [OPCODE_LENGTH-1:0] alu_op;
    logic [DATA_WIDTH-1:0]    alu_result;

    logic [1:0]               rsp_valid;
    logic [1:0]               rsp_ready;
    logic [DATA_WIDTH-1:0]    rsp_data0;
    logic [DATA_WIDTH-1:0]    rsp_data1;

    modport master (
        output req_valid, req_srca0, req_srca1, req_srcb0, req_srcb1, req_op0, req_op1,
        input  req_ready,
        input  alu_srca, alu_srcb, alu_op,
        output alu_result,
        input  rsp_valid, rsp_data0, rsp_data1,
        output rsp_ready
    );

    modport slave (
        input  req_valid, req_srca0, req_srca1, req_srcb0, req_srcb1, req_op0, req_op1,
        output req_ready,
        output alu_srca, alu_srcb, alu_op,
        input  alu_result,
        output rsp_valid, rsp_data0, rsp_data1,
        input  rsp_ready
    );
endinterface

// File: rtl/alu_arbiter.sv
// Round-robin sharing of one combinational alu between two requesters, with a
// single registered execute stage and one response register per requester.
// Optional feature macro: ALU_ARB_STATS_EN adds saturating per-requester grant
// counters (grant_cnt0/1) and a synchronous stats_clr input.
module alu_arbiter #(
    parameter int unsigned DATA_WIDTH    = 32,
    parameter int unsigned OPCODE_LENGTH = 4
) (
    input  logic          clk,
    input  logic          rst_n,
`ifdef ALU_ARB_STATS_EN
    input  logic          stats_clr,
    output logic [15:0]   grant_cnt0,
    output logic [15:0]   grant_cnt1,
`endif
    alu_arbiter_if.slave  bus
);
    localparam int unsigned NREQ = 2;

    typedef enum logic [1:0] {
        FREE     = 2'd0,
        INFLIGHT = 2'd1,
        DONE     = 2'd2
    } slot_e;

    slot_e                    slot_q     [NREQ];
    logic [DATA_WIDTH-1:0]    rsp_data_q [NREQ];
    logic                     last_grant_q;
    logic                     ex_vld_q;
    logic                     ex_id_q;
    logic [DATA_WIDTH-1:0]    ex_srca_q;
    logic [DATA_WIDTH-1:0]    ex_srcb_q;
    logic [OPCODE_LENGTH-1:0] ex_op_q;

    logic [NREQ-1:0]          elig_c;
    logic [NREQ-1:0]          grant_c;
    logic                     any_grant_c;
    logic                     grant_id_c;

    // Eligibility and round-robin pick; a DONE slot may re-issue only when popped this cycle.
    always_comb begin
        elig_c  = '0;
        grant_c = '0;
        for (int i = 0; i < NREQ; i++) begin
            elig_c[i] = bus.req_valid[i] &&
                        ((slot_q[i] == FREE) || ((slot_q[i] == DONE) && bus.rsp_ready[i]));
        end
        if (elig_c == 2'b11) begin
            grant_c = last_grant_q ? 2'b01 : 2'b10;
        end else begin
            grant_c = elig_c;
        end
    end

    assign any_grant_c   = |grant_c;
    assign grant_id_c    = grant_c[1];
    assign bus.req_ready = grant_c;

    // Idle execute registers are zero, so the alu sees a quiet AND of zeros.
    assign bus.alu_srca  = ex_srca_q;
    assign bus.alu_srcb  = ex_srcb_q;
    assign bus.alu_op    = ex_op_q;

    assign bus.rsp_valid = {slot_q[1] == DONE, slot_q[0] == DONE};
    assign bus.rsp_data0 = rsp_data_q[0];
    assign bus.rsp_data1 = rsp_data_q[1];

    // Execute stage, round-robin pointer, response capture and per-requester slot FSMs.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            last_grant_q <= 1'b1;
            ex_vld_q     <= 1'b0;
            ex_id_q      <= 1'b0;
            ex_srca_q    <= '0;
            ex_srcb_q    <= '0;
            ex_op_q      <= '0;
            for (int i = 0; i < NREQ; i++) begin
                slot_q[i]     <= FREE;
                rsp_data_q[i] <= '0;
            end
        end else begin
            ex_vld_q <= any_grant_c;
            ex_id_q  <= grant_id_c;
            if (any_grant_c) begin
                last_grant_q <= grant_id_c;
                ex_srca_q    <= grant_id_c ? bus.req_srca1 : bus.req_srca0;
                ex_srcb_q    <= grant_id_c ? bus.req_srcb1 : bus.req_srcb0;
                ex_op_q      <= grant_id_c ? bus.req_op1   : bus.req_op0;
            end else begin
                ex_srca_q <= '0;
                ex_srcb_q <= '0;
                ex_op_q   <= '0;
            end
            for (int i = 0; i < NREQ; i++) begin
                if (ex_vld_q && (ex_id_q == 1'(i))) begin
                    rsp_data_q[i] <= bus.alu_result;
                end
                case (slot_q[i])
                    FREE: begin
                        if (grant_c[i]) slot_q[i] <= INFLIGHT;
                    end
                    INFLIGHT: begin
                        slot_q[i] <= DONE;
                    end
                    DONE: begin
                        if (grant_c[i]) begin
                            slot_q[i] <= INFLIGHT;
                        end else if (bus.rsp_ready[i]) begin
                            slot_q[i] <= FREE;
                        end
                    end
                    default: begin
                        slot_q[i] <= FREE;
                    end
                endcase
            end
        end
    end

`ifdef ALU_ARB_STATS_EN
    logic [15:0] cnt0_q;
    logic [15:0] cnt1_q;

    // Saturating accept counters; a clear beats a same-cycle increment.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else if (stats_clr) begin
            cnt0_q <= '0;
            cnt1_q <= '0;
        end else begin
            if (grant_c[0] && (cnt0_q != 16'hFFFF)) cnt0_q <= cnt0_q + 16'd1;
            if (grant_c[1] && (cnt1_q != 16'hFFFF)) cnt1_q <= cnt1_q + 16'd1;
        end
    end

    assign grant_cnt0 = cnt0_q;
    assign grant_cnt1 = cnt1_q;
`endif

endmodule

// File: tb/tb_alu_arbiter.sv
// Directed bench for alu_arbiter with a small stand-in alu driving alu_result.
// Honours ALU_ARB_STATS_EN the same way the design does.
module tb_alu_arbiter;
    localparam int unsigned DW = 32;
    localparam int unsigned OW = 4;

    localparam logic [OW-1:0] OP_AND  = 4'b0000;
    localparam logic [OW-1:0] OP_ADD  = 4'b0010;
    localparam logic [OW-1:0] OP_SUB  = 4'b0110;
    localparam logic [OW-1:0] OP_SLTU = 4'b1001;
    localparam logic [OW-1:0] OP_GEU  = 4'b1111;

    logic clk;
    logic rst_n;
    int   checks;
    int   errors;

    alu_arbiter_if #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) bus ();

`ifdef ALU_ARB_STATS_EN
    logic        stats_clr;
    logic [15:0] grant_cnt0;
    logic [15:0] grant_cnt1;
`endif

    alu_arbiter #(.DATA_WIDTH(DW), .OPCODE_LENGTH(OW)) dut (
        .clk        (clk),
        .rst_n      (rst_n),
`ifdef ALU_ARB_STATS_EN
        .stats_clr  (stats_clr),
        .grant_cnt0 (grant_cnt0),
        .grant_cnt1 (grant_cnt1),
`endif
        .bus        (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Stand-in combinational alu.
    always_comb begin
        case (bus.alu_op)
            OP_AND:  bus.alu_result = bus.alu_srca & bus.alu_srcb;
            OP_ADD:  bus.alu_result = bus.alu_srca + bus.alu_srcb;
            OP_SUB:  bus.alu_result = bus.alu_srca - bus.alu_srcb;
            OP_SLTU: bus.alu_result = {31'd0, bus.alu_srca <  bus.alu_srcb};
            OP_GEU:  bus.alu_result = {31'd0, bus.alu_srca >= bus.alu_srcb};
            default: bus.alu_result = '0;
        endcase
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic set_req0(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_op0   = op;
        bus.req_srca0 = a;
        bus.req_srcb0 = b;
    endtask

    task automatic set_req1(input logic [OW-1:0] op, input logic [DW-1:0] a, input logic [DW-1:0] b);
        bus.req_op1   = op;
        bus.req_srca1 = a;
        bus.req_srcb1 = b;
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n = 1'b0;
        #2;
        @(negedge clk);
        rst_n = 1'b1;
        #1;
    endtask

    initial begin
        int id;
        checks        = 0;
        errors        = 0;
        rst_n         = 1'b0;
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        set_req0(OP_AND, '0, '0);
        set_req1(OP_AND, '0, '0);
`ifdef ALU_ARB_STATS_EN
        stats_clr = 1'b0;
`endif

        // Reset state
        #12;
        check("rst_req_ready", 32'(bus.req_ready), 32'h0);
        check("rst_rsp_valid", 32'(bus.rsp_valid), 32'h0);
        check("rst_rsp_data0", bus.rsp_data0, 32'h0);
        check("rst_alu_op", 32'(bus.alu_op), 32'h0);
        check("rst_alu_srca", bus.alu_srca, 32'h0);
`ifdef ALU_ARB_STATS_EN
        check("rst_cnt0", 32'(grant_cnt0), 32'h0);
`endif
        do_reset();

        // Both valid right after reset: req0 first, req1 next cycle
        @(posedge clk); #1;
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        set_req0(OP_SUB, 32'd10, 32'd3);
        set_req1(OP_AND, 32'hF0, 32'h3C);
        #1;
        check("t2_grant0", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b10;
        #1;
        check("t2_grant1", 32'(bus.req_ready), 32'h2);
        check("t2_alu_op0", 32'(bus.alu_op), 32'(OP_SUB));
        check("t2_alu_srca0", bus.alu_srca, 32'd10);
        tick();
        bus.req_valid = 2'b00;
        check("t2_rsp_valid_a", 32'(bus.rsp_valid), 32'h1);
        check("t2_rsp_data0", bus.rsp_data0, 32'd7);
        check("t2_alu_srcb1", bus.alu_srcb, 32'h3C);
        tick();
        check("t2_rsp_valid_b", 32'(bus.rsp_valid), 32'h2);
        check("t2_rsp_data1", bus.rsp_data1, 32'h30);
        check("t2_rsp_data0_kept", bus.rsp_data0, 32'd7);
        tick();
        check("t2_drained", 32'(bus.rsp_valid), 32'h0);
        check("t2_alu_idle", bus.alu_srca, 32'h0);

        // Single requester ADD 5+7, then back-pressure and pop+accept
        bus.rsp_ready = 2'b00;
        bus.req_valid = 2'b01;
        set_req0(OP_ADD, 32'd5, 32'd7);
        #1;
        check("t1_ready", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        check("t1_inflight_valid", 32'(bus.rsp_valid), 32'h0);
        check("t1_alu_srca", bus.alu_srca, 32'd5);
        check("t1_alu_srcb", bus.alu_srcb, 32'd7);
        check("t1_alu_op", 32'(bus.alu_op), 32'(OP_ADD));
        tick();
        check("t1_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("t1_rsp_data0", bus.rsp_data0, 32'd12);
        check("t1_alu_zero", 32'(bus.alu_op), 32'h0);
        bus.req_valid = 2'b01;
        set_req0(OP_SUB, 32'd9, 32'd4);
        #1;
        check("t3_blocked", 32'(bus.req_ready), 32'h0);
        tick();
        check("t3_held_valid", 32'(bus.rsp_valid), 32'h1);
        check("t3_held_data", bus.rsp_data0, 32'd12);
        bus.rsp_ready = 2'b01;
        #1;
        check("t3_pop_accept", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        bus.rsp_ready = 2'b00;
        check("t3_reissued", 32'(bus.rsp_valid), 32'h0);
        check("t3_data_kept", bus.rsp_data0, 32'd12);
        tick();
        check("t3_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("t3_rsp_data0", bus.rsp_data0, 32'd5);
        bus.rsp_ready = 2'b01;
        tick();
        bus.rsp_ready = 2'b00;
        check("t3_popped", 32'(bus.rsp_valid), 32'h0);

        // Both continuously valid: alternating grants, one response per cycle
        // (last grant was req0, so req1 leads)
        bus.rsp_ready = 2'b11;
        bus.req_valid = 2'b11;
        set_req0(OP_SLTU, 32'd1, 32'd2);
        set_req1(OP_SUB, 32'd100, 32'd1);
        for (int i = 0; i < 6; i++) begin
            id = (i + 1) % 2;
            #1;
            check("t4_grant", 32'(bus.req_ready), (id == 0) ? 32'h1 : 32'h2);
            if (i >= 2) begin
                check("t4_rsp_valid", 32'(bus.rsp_valid), (id == 0) ? 32'h1 : 32'h2);
                check("t4_rsp_data", (id == 0) ? bus.rsp_data0 : bus.rsp_data1,
                      (id == 0) ? 32'd1 : 32'd99);
            end
            tick();
        end
        bus.req_valid = 2'b00;
        tick();
        tick();
        tick();
        check("t4_drained", 32'(bus.rsp_valid), 32'h0);

        // Reset while req1 is in flight
        bus.req_valid = 2'b10;
        set_req1(OP_ADD, 32'd3, 32'd4);
        #1;
        check("t5_grant1", 32'(bus.req_ready), 32'h2);
        tick();
        bus.req_valid = 2'b00;
        check("t5_alu_op_busy", 32'(bus.alu_op), 32'(OP_ADD));
        rst_n = 1'b0;
        #1;
        check("t5_async_alu_op", 32'(bus.alu_op), 32'h0);
        check("t5_async_rsp_data1", bus.rsp_data1, 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        tick();
        check("t5_no_rsp_a", 32'(bus.rsp_valid), 32'h0);
        tick();
        check("t5_no_rsp_b", 32'(bus.rsp_valid), 32'h0);
        bus.req_valid = 2'b11;
        set_req0(OP_AND, 32'hFF, 32'h0F);
        #1;
        check("t5_req0_first", 32'(bus.req_ready), 32'h1);
        tick();
        bus.req_valid = 2'b00;
        tick();
        check("t5_rsp_valid", 32'(bus.rsp_valid), 32'h1);
        check("t5_rsp_data0", bus.rsp_data0, 32'h0F);
        tick();

`ifdef ALU_ARB_STATS_EN
        // Saturation and clear-beats-increment
        check("t6_cnt0_start", 32'(grant_cnt0), 32'h1);
        @(negedge clk);
        force dut.cnt0_q = 16'hFFFE;
        #1;
        release dut.cnt0_q;
        tick();
        for (int i = 0; i < 3; i++) begin
            bus.req_valid = 2'b01;
            tick();
            bus.req_valid = 2'b00;
            tick();
        end
        check("t6_cnt0_sat", 32'(grant_cnt0), 32'hFFFF);
        bus.req_valid = 2'b01;
        stats_clr     = 1'b1;
        #1;
        check("t6_clr_grant", 32'(bus.req_ready), 32'h1);
        tick();
        stats_clr     = 1'b0;
        bus.req_valid = 2'b00;
        check("t6_cnt0_clr", 32'(grant_cnt0), 32'h0);
        check("t6_cnt1_clr", 32'(grant_cnt1), 32'h0);
        tick();
        tick();
`endif

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

    // Global watchdog
    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end
endmodule
